alu_pipe: RTL



---
 rtl/alu_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides and an internal {N,Z,V} flag register.
// Define ALU_MUL_EN to add an iterative unsigned multiplier (ext=1, opcode=0); default build has none.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4,
    parameter int IMM_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             ext,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_RED    = 4'd2,
        OP_XOR    = 4'd3,
        OP_SLL    = 4'd4,
        OP_SRA    = 4'd5,
        OP_ROR    = 4'd6,
        OP_PADDSB = 4'd7
    } op_e;

    localparam int NL = WIDTH / LANE_W;
    localparam logic [WIDTH-1:0]  WMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  WMAX = ~WMIN;
    localparam logic [LANE_W-1:0] LMIN = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [LANE_W-1:0] LMAX = ~LMIN;

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [IMM_W-1:0] s1_imm;
    logic             advance;

`ifdef ALU_MUL_EN
    typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_e;
    localparam int CW = $clog2(WIDTH);

    logic               s1_ext;
    mul_state_e         mul_state;
    logic [CW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic               mul_start;

    // The output register is owned by the multiplier while it runs, so nothing may advance.
    assign advance      = (mul_state == MUL_IDLE) && (!out_valid || out_ready);
    assign mul_start    = advance && s1_valid && s1_ext && (s1_op == OP_ADD);
    assign mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
`else
    logic unused_ext;
    assign unused_ext = ext;
    assign advance    = !out_valid || out_ready;
`endif

    assign in_ready = !s1_valid || advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_imm   <= '0;
`ifdef ALU_MUL_EN
            s1_ext   <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= opcode;
                s1_a   <= src_a;
                s1_b   <= src_b;
                s1_imm <= imm;
`ifdef ALU_MUL_EN
                s1_ext <= ext;
`endif
            end
        end
    end

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [WIDTH-1:0] add_sat;
    logic [WIDTH-1:0] red_acc;
    logic [WIDTH-1:0] padd_res;
    logic [LANE_W-1:0] la, lb, ls;
    logic             lovf;
    logic [31:0]      sh_amt;
    logic [WIDTH-1:0] imm_sx;
    logic [WIDTH-1:0] addr_res;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       alu_flags;

    always_comb begin
        is_sub   = (s1_op == OP_SUB);
        b_eff    = is_sub ? ~s1_b : s1_b;
        sum      = s1_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
        add_ovf  = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        add_sat  = add_ovf ? (s1_a[WIDTH-1] ? WMIN : WMAX) : sum;

        red_acc  = '0;
        padd_res = '0;
        la       = '0;
        lb       = '0;
        ls       = '0;
        lovf     = 1'b0;
        for (int unsigned i = 0; i < NL; i++) begin
            la       = s1_a[i*LANE_W +: LANE_W];
            lb       = s1_b[i*LANE_W +: LANE_W];
            red_acc  = red_acc + WIDTH'($signed(la)) + WIDTH'($signed(lb));
            ls       = la + lb;
            lovf     = (la[LANE_W-1] == lb[LANE_W-1]) && (ls[LANE_W-1] != la[LANE_W-1]);
            padd_res[i*LANE_W +: LANE_W] = lovf ? (la[LANE_W-1] ? LMIN : LMAX) : ls;
        end

        sh_amt   = 32'(s1_imm) % 32'(WIDTH);
        imm_sx   = WIDTH'($signed(s1_imm));
        addr_res = s1_a + {imm_sx[WIDTH-2:0], 1'b0};

        alu_res   = addr_res;
        alu_flags = flags;
        if (!s1_op[3]) begin
            case (s1_op)
                OP_ADD, OP_SUB: begin
                    alu_res   = add_sat;
                    alu_flags = {add_sat[WIDTH-1], add_sat == '0, add_ovf};
                end
                OP_RED:    alu_res = red_acc;
                OP_XOR:    alu_res = s1_a ^ s1_b;
                OP_SLL:    alu_res = s1_a << sh_amt;
                OP_SRA:    alu_res = $signed(s1_a) >>> sh_amt;
                OP_ROR:    alu_res = (s1_a >> sh_amt) | (s1_a << (32'(WIDTH) - sh_amt));
                default:   alu_res = padd_res;
            endcase
            if (s1_op == OP_XOR || s1_op == OP_SLL || s1_op == OP_SRA || s1_op == OP_ROR)
                alu_flags[1] = (alu_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            flags      <= '0;
`ifdef ALU_MUL_EN
            mul_state  <= MUL_IDLE;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
`endif
        end else begin
`ifdef ALU_MUL_EN
            if (mul_state == MUL_RUN) begin
                mul_acc    <= mul_acc_next;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + 1'b1;
                if (mul_cnt == CW'(WIDTH-1)) begin
                    mul_state <= MUL_IDLE;
                    out_valid <= 1'b1;
                    result    <= mul_acc_next[WIDTH-1:0];
                    flags     <= {mul_acc_next[WIDTH-1], mul_acc_next[WIDTH-1:0] == '0,
                                  mul_acc_next[2*WIDTH-1:WIDTH] != '0};
                end
            end else if (mul_start) begin
                // S1 empties into the multiplier; the previous result was consumed by this advance.
                mul_state  <= MUL_RUN;
                out_valid  <= 1'b0;
                mul_cnt    <= '0;
                mul_acc    <= '0;
                mul_mcand  <= {{WIDTH{1'b0}}, s1_a};
                mul_mplier <= s1_b;
            end else
`endif
            if (advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    result <= alu_res;
                    flags  <= alu_flags;
                end
            end
        end
    end

endmodule
